mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 146 ++++++++++++++
 tb/tb_mem_access.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage issuing byte/half/word loads and stores over a
// req/ack bus, with misalignment detection and an ack timeout.
module mem_access #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic        hold_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stallreq,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_sel_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i,
    input  logic        mem_ack_i,
    output logic        mem_err_o
);
    localparam logic [7:0] EXE_LB_OP  = 8'b11100000;
    localparam logic [7:0] EXE_LH_OP  = 8'b11100001;
    localparam logic [7:0] EXE_LW_OP  = 8'b11100011;
    localparam logic [7:0] EXE_LBU_OP = 8'b11100100;
    localparam logic [7:0] EXE_LHU_OP = 8'b11100101;
    localparam logic [7:0] EXE_SB_OP  = 8'b11101000;
    localparam logic [7:0] EXE_SH_OP  = 8'b11101001;
    localparam logic [7:0] EXE_SW_OP  = 8'b11101011;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t state, state_nx;

    logic [7:0]  cnt, op_r;
    logic [31:0] addr_r, data_r, rdata;
    logic [3:0]  sel_r;
    logic        we_r, err;
    logic        is_ld, is_st, is_mem, is_half, is_word, misaligned, timeout_hit;
    logic [3:0]  sel_nx;
    logic [31:0] data_nx, ld_data;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign is_ld = aluop_i inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
    assign is_st = aluop_i inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    assign is_mem = is_ld | is_st;
    assign is_half = aluop_i inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP};
    assign is_word = aluop_i inside {EXE_LW_OP, EXE_SW_OP};
    assign misaligned = (is_half & mem_addr_i[0]) | (is_word & |mem_addr_i[1:0]);
    assign timeout_hit = cnt + 8'd1 == 8'(TIMEOUT);

    // Big-endian lanes: byte address 0 of a word lives in sel bit 3 / data[31:24]
    assign sel_nx = is_word ? 4'b1111 : is_half ? (mem_addr_i[1] ? 4'b0011 : 4'b1100)
                  : 4'b1000 >> mem_addr_i[1:0];
    assign data_nx = aluop_i == EXE_SB_OP ? {4{reg2_i[7:0]}}
                   : aluop_i == EXE_SH_OP ? {2{reg2_i[15:0]}}
                   : aluop_i == EXE_SW_OP ? reg2_i : '0;

    assign lane_b = 8'(rdata >> {~addr_r[1:0], 3'b000});
    assign lane_h = addr_r[1] ? rdata[15:0] : rdata[31:16];
    assign ld_data = op_r == EXE_LB_OP  ? {{24{lane_b[7]}}, lane_b}
                   : op_r == EXE_LBU_OP ? {24'b0, lane_b}
                   : op_r == EXE_LH_OP  ? {{16{lane_h[15]}}, lane_h}
                   : op_r == EXE_LHU_OP ? {16'b0, lane_h} : rdata;

    assign mem_req_o = state == REQ;
    assign mem_we_o = mem_req_o & we_r;
    assign mem_addr_o = mem_req_o ? {addr_r[31:2], 2'b00} : '0;
    assign mem_sel_o = mem_req_o ? sel_r : '0;
    assign mem_data_o = mem_req_o ? data_r : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            op_r <= '0;
            addr_r <= '0;
            data_r <= '0;
            sel_r <= '0;
            we_r <= 1'b0;
            rdata <= '0;
            err <= 1'b0;
        end else begin
            if (state == IDLE && state_nx == REQ) begin
                op_r <= aluop_i;
                addr_r <= mem_addr_i;
                sel_r <= sel_nx;
                data_r <= data_nx;
                we_r <= is_st;
                cnt <= '0;
            end else if (state == REQ && !mem_ack_i) begin
                cnt <= cnt + 8'd1;
            end
            if (state == REQ && mem_ack_i) rdata <= mem_data_i;
            err <= state == REQ ? (!mem_ack_i && timeout_hit) : state == DONE ? (err && hold_i) : 1'b0;
        end
    end

    // Combinational outputs are also forced to zero while reset is held low
    always_comb begin
        state_nx = state;
        wd_o = '0;
        wreg_o = 1'b0;
        wdata_o = '0;
        stallreq = 1'b0;
        mem_err_o = 1'b0;
        if (reset) begin
            case (state)
                IDLE: begin
                    wd_o = wd_i;
                    if (!is_mem) begin
                        wreg_o = wreg_i;
                        wdata_o = wdata_i;
                    end else if (misaligned) begin
                        mem_err_o = 1'b1;
                    end else begin
                        stallreq = 1'b1;
                        state_nx = REQ;
                    end
                end
                REQ: begin
                    stallreq = 1'b1;
                    state_nx = (mem_ack_i || timeout_hit) ? DONE : REQ;
                end
                DONE: begin
                    wd_o = wd_i;
                    mem_err_o = err;
                    wreg_o = !we_r && !err && wreg_i;
                    wdata_o = (!we_r && !err) ? ld_data : '0;
                    state_nx = hold_i ? DONE : IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed transactions against a transaction-level model of the
// MEM stage; a negedge compare process checks every output each active cycle.
module tb_mem_access;
    localparam int TO = 4;
    localparam logic [7:0] LB = 8'b11100000, LH = 8'b11100001, LW = 8'b11100011;
    localparam logic [7:0] LBU = 8'b11100100, LHU = 8'b11100101;
    localparam logic [7:0] SB = 8'b11101000, SH = 8'b11101001, SW = 8'b11101011;
    localparam logic [7:0] ADD = 8'b00100000;

    logic        clk = 0, reset;
    logic [7:0]  aluop_i;
    logic [31:0] mem_addr_i, reg2_i, wdata_i, mem_data_i;
    logic [4:0]  wd_i;
    logic        wreg_i, hold_i, mem_ack_i;
    logic [4:0]  wd_o;
    logic        wreg_o, stallreq, mem_req_o, mem_we_o, mem_err_o;
    logic [31:0] wdata_o, mem_addr_o, mem_data_o;
    logic [3:0]  mem_sel_o;

    mem_access #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i),
        .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .hold_i(hold_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .stallreq(stallreq), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_sel_o(mem_sel_o), .mem_data_o(mem_data_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i), .mem_err_o(mem_err_o)
    );

    always #5 clk = ~clk;

    int nchk = 0, nerr = 0, xfers = 0;
    bit chk_en = 0, e_stall, e_wreg, e_req, e_err, e_chkwd, e_we, l_req, l_w;
    logic [31:0] e_wdata, e_addr, e_data, l_addr, l_data, l_wdata;
    logic [3:0]  e_sel, l_sel;
    logic [4:0]  e_wd;

    always @(posedge mem_req_o) xfers++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) if (chk_en) begin
        chk("stallreq", 32'(stallreq), 32'(e_stall));
        chk("wreg_o", 32'(wreg_o), 32'(e_wreg));
        chk("mem_req_o", 32'(mem_req_o), 32'(e_req));
        chk("mem_err_o", 32'(mem_err_o), 32'(e_err));
        if (e_req) begin
            chk("mem_addr_o", mem_addr_o, e_addr);
            chk("mem_sel_o", 32'(mem_sel_o), 32'(e_sel));
            chk("mem_we_o", 32'(mem_we_o), 32'(e_we));
            if (e_we) chk("mem_data_o", mem_data_o, e_data);
        end
        if (e_chkwd) begin
            chk("wd_o", 32'(wd_o), 32'(e_wd));
            chk("wdata_o", wdata_o, e_wdata);
        end
        if (l_req && e_req) begin
            chk("lit_addr", mem_addr_o, l_addr);
            chk("lit_sel", 32'(mem_sel_o), 32'(l_sel));
            if (e_we) chk("lit_data", mem_data_o, l_data);
        end
        if (l_w) chk("lit_wdata", wdata_o, l_wdata);
    end

    function automatic int sz(input logic [7:0] op);
        return (op == LB || op == LBU || op == SB) ? 1 : (op == LH || op == LHU || op == SH) ? 2 : 4;
    endfunction

    function automatic logic [31:0] mask_of(input int s);
        return s == 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * s)) - 32'd1;
    endfunction

    function automatic logic [3:0] m_sel(input logic [7:0] op, input logic [31:0] a);
        logic [3:0] r;
        int base, s;
        s = sz(op);
        base = int'(a % 4);
        for (int k = 0; k < 4; k++) r[3-k] = (k >= base && k < base + s);
        return r;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [7:0] op, input logic [31:0] v);
        logic [31:0] r;
        int s;
        s = sz(op);
        r = '0;
        for (int i = 0; i < 4 / s; i++) r |= (v & mask_of(s)) << (8 * s * i);
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] v;
        int s, base;
        s = sz(op);
        base = int'(a % 4);
        v = (d >> (8 * (4 - base - s))) & mask_of(s);
        if ((op == LB || op == LH) && v[8*s-1]) v |= ~mask_of(s);
        return v;
    endfunction

    task automatic cycle_exp(input bit stall, input bit wreg, input bit req, input bit err,
                             input bit chkwd, input logic [31:0] wdat);
        e_stall = stall; e_wreg = wreg; e_req = req; e_err = err; e_chkwd = chkwd; e_wdata = wdat;
        chk_en = 1;
        @(posedge clk); #1;
    endtask

    task automatic nop(input logic [4:0] wd, input bit wreg, input logic [31:0] wdat);
        aluop_i = ADD; wd_i = wd; wreg_i = wreg; wdata_i = wdat; e_wd = wd;
        cycle_exp(0, wreg, 0, 0, 1, wdat);
    endtask

    // n_wait: REQ cycles without ack before the ack cycle; negative means never ack
    task automatic do_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                          input logic [31:0] rd, input int n_wait, input int hold, input bit lit,
                          input logic [31:0] lw, input logic [31:0] la, input logic [31:0] ld,
                          input logic [3:0] ls);
        bit st, to;
        int s;
        s = sz(op);
        st = (op == SB || op == SH || op == SW);
        to = n_wait < 0;
        aluop_i = op; mem_addr_i = addr; reg2_i = reg2; wd_i = addr[4:0] ^ 5'h15; wreg_i = 1;
        wdata_i = 32'hDEAD_0000 | addr; hold_i = 0; mem_ack_i = 0;
        e_wd = wd_i; e_addr = addr & ~32'd3; e_sel = m_sel(op, addr); e_we = st; e_data = m_wdata(op, reg2);
        if (addr % s != 0) begin
            cycle_exp(0, 0, 0, 1, 0, 0);
        end else begin
            l_req = lit; l_addr = la; l_sel = ls; l_data = ld;
            cycle_exp(1, 0, 0, 0, 0, 0);
            if (to) begin
                repeat (TO) cycle_exp(1, 0, 1, 0, 0, 0);
            end else begin
                repeat (n_wait) cycle_exp(1, 0, 1, 0, 0, 0);
                mem_ack_i = 1; mem_data_i = rd;
                cycle_exp(1, 0, 1, 0, 0, 0);
                mem_ack_i = 0; mem_data_i = ~rd;
            end
            l_req = 0;
            l_w = lit && !st && !to; l_wdata = lw;
            for (int h = 0; h <= hold; h++) begin
                hold_i = h < hold;
                if (to) cycle_exp(0, 0, 0, 1, 0, 0);
                else cycle_exp(0, !st, 0, 0, 1, st ? 32'd0 : m_load(op, addr, rd));
            end
            l_w = 0; hold_i = 0;
        end
        aluop_i = ADD; wreg_i = 0;
    endtask

    initial begin
        int x0;
        reset = 0; aluop_i = ADD; mem_addr_i = 0; reg2_i = 0; wd_i = 5'h1F; wreg_i = 1;
        wdata_i = 32'hFFFF_FFFF; hold_i = 0; mem_ack_i = 0; mem_data_i = 0;
        l_req = 0; l_w = 0;
        #2;
        chk("rst_wd_o", 32'(wd_o), 0);
        chk("rst_wreg_o", 32'(wreg_o), 0);
        chk("rst_wdata_o", wdata_o, 0);
        chk("rst_stallreq", 32'(stallreq), 0);
        chk("rst_mem_req_o", 32'(mem_req_o), 0);
        chk("rst_bus", {mem_addr_o[27:0], mem_sel_o}, 0);
        chk("rst_err_we", 32'({mem_err_o, mem_we_o}), 0);
        @(posedge clk); #1;
        reset = 1;

        nop(5'd3, 1, 32'h1234_5678);
        nop(5'd17, 0, 32'hA5A5_0F0F);
        mem_ack_i = 1;
        nop(5'd8, 1, 32'h0000_0042);
        mem_ack_i = 0;

        do_mem(LB, 32'h1001, 0, 32'h12F4_5678, 0, 0, 1, 32'hFFFF_FFF4, 32'h1000, 0, 4'b0100);
        do_mem(SH, 32'h2002, 32'h0000_ABCD, 0, 1, 0, 1, 0, 32'h2000, 32'hABCD_ABCD, 4'b0011);
        do_mem(LW, 32'h3002, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nop(5'd1, 1, 32'h7);
        do_mem(LH, 32'h1003, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_mem(SW, 32'h5001, 32'h1111_2222, 0, 0, 0, 0, 0, 0, 0, 0);
        do_mem(LH, 32'h1002, 0, 32'h1234_8765, 0, 0, 1, 32'hFFFF_8765, 32'h1000, 0, 4'b0011);
        do_mem(LW, 32'h0000_0100, 0, 0, -1, 0, 0, 0, 0, 0, 0);
        nop(5'd2, 1, 32'h99);
        x0 = xfers;
        do_mem(LHU, 32'h40, 0, 32'h8001_5A5A, 2, 2, 1, 32'h0000_8001, 32'h40, 0, 4'b1100);
        chk("lhu_xfers", 32'(xfers - x0), 1);
        do_mem(LW, 32'h3000, 0, 32'hCAFE_F00D, TO - 1, 0, 1, 32'hCAFE_F00D, 32'h3000, 0, 4'b1111);
        do_mem(SB, 32'h7003, 32'h1234_565A, 0, 0, 1, 1, 0, 32'h7000, 32'h5A5A_5A5A, 4'b0001);
        do_mem(LBU, 32'h13, 0, 32'h0000_00C3, 1, 0, 1, 32'h0000_00C3, 32'h10, 0, 4'b0001);
        do_mem(LB, 32'h10, 0, 32'h80FF_FFFF, 0, 0, 1, 32'hFFFF_FF80, 32'h10, 0, 4'b1000);
        do_mem(SW, 32'h44, 32'h0102_0304, 0, 0, 0, 1, 0, 32'h44, 32'h0102_0304, 4'b1111);

        aluop_i = LW; mem_addr_i = 32'h200; wd_i = 5'd4; wreg_i = 1; e_wd = 5'd4;
        e_addr = 32'h200; e_sel = 4'b1111; e_we = 0;
        cycle_exp(1, 0, 0, 0, 0, 0);
        chk_en = 0;
        #2;
        chk("midreq_req_before", 32'(mem_req_o), 1);
        reset = 0;
        aluop_i = ADD; wd_i = 5'h1E; wreg_i = 1; wdata_i = 32'h5555_AAAA;
        #1;
        chk("midreq_rst_req", 32'(mem_req_o), 0);
        chk("midreq_rst_outs", {wdata_o[26:0], wd_o}, 0);
        chk("midreq_rst_flags", 32'({wreg_o, stallreq, mem_err_o, mem_we_o, mem_sel_o}), 0);
        @(posedge clk); #1;
        reset = 1; mem_ack_i = 1; mem_data_i = 32'hBAD0_BAD0;
        wd_i = 0; wreg_i = 0; wdata_i = 0;
        e_wd = 0;
        cycle_exp(0, 0, 0, 0, 1, 0);
        mem_ack_i = 0;
        nop(5'd9, 1, 32'h0BAD_F00D);
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
